// File: rtl/vai_mgr_pkg.sv
// Shared definitions for the VAI manager CSR block: register map, DFH/ID constants
// and the subset of CCI-P channel structures this block touches.
package vai_mgr_pkg;

  localparam int VAI_MAX_SUB_AFUS = 64;

  localparam logic [14:0] IDX_DFH         = 15'd0;
  localparam logic [14:0] IDX_ID_LO       = 15'd1;
  localparam logic [14:0] IDX_ID_HI       = 15'd2;
  localparam logic [14:0] IDX_RESET_PULSE = 15'd3;
  localparam logic [14:0] IDX_RESET_LEVEL = 15'd4;
  localparam logic [14:0] IDX_ENABLE      = 15'd5;
  localparam logic [14:0] IDX_SCRATCH     = 15'd6;
  localparam logic [14:0] IDX_OFFSET_BASE = 15'd8;

  localparam logic [63:0]  VAI_MGR_DFH        = 64'h1000_0100_0000_0000;
  localparam logic [127:0] VAI_MGR_DEFAULT_ID = 128'hd1d383aaca4c4c60a0a013a421139e69;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_DFH,
    REG_ID_LO,
    REG_ID_HI,
    REG_PULSE,
    REG_LEVEL,
    REG_ENABLE,
    REG_SCRATCH,
    REG_OFFSET
  } t_reg_sel;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  typedef struct packed {
    logic [73:0] hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [79:0]  hdr;
    logic [511:0] data;
    logic         valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  // Offset window sits above the fixed registers and is sized by the sub-AFU count.
  function automatic t_reg_sel vai_decode(input logic [14:0] idx, input int num_sub);
    t_reg_sel sel;
    sel = REG_NONE;
    if (idx == IDX_DFH)                 sel = REG_DFH;
    else if (idx == IDX_ID_LO)          sel = REG_ID_LO;
    else if (idx == IDX_ID_HI)          sel = REG_ID_HI;
    else if (idx == IDX_RESET_PULSE)    sel = REG_PULSE;
    else if (idx == IDX_RESET_LEVEL)    sel = REG_LEVEL;
    else if (idx == IDX_ENABLE)         sel = REG_ENABLE;
    else if (idx == IDX_SCRATCH)        sel = REG_SCRATCH;
    else if (idx >= IDX_OFFSET_BASE && int'(idx) < int'(IDX_OFFSET_BASE) + num_sub)
      sel = REG_OFFSET;
    return sel;
  endfunction

endpackage

// File: rtl/vai_reset_pulse.sv
// Self-timed reset pulse for one sub-AFU: loads RESET_CYCLES and counts down to zero.
module vai_reset_pulse #(
  parameter int RESET_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic active
);

  localparam int CW = $clog2(RESET_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Starts loaded so every sub-AFU sits in reset for a full pulse after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= CW'(RESET_CYCLES);
    else if (load)
      cnt <= CW'(RESET_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/vai_mgr_csr.sv
// MMIO CSR block for the VAI mux manager: four-stage capture/decode/update/respond
// pipeline driving sub-AFU offsets, enables and resets.
module vai_mgr_csr
  import vai_mgr_pkg::*;
#(
  parameter int           NUM_SUB_AFUS = 8,
  parameter int           RESET_CYCLES = 16,
  parameter logic [127:0] MGR_ID       = VAI_MGR_DEFAULT_ID
) (
  input  logic                           pClk,
  input  logic                           pck_cp2af_softReset_n,
  input  t_if_ccip_Rx                    pck_cp2af_sRx,
  output t_if_ccip_Tx                    pck_af2cp_sTx,
  output logic [NUM_SUB_AFUS-1:0][63:0]  offset_array,
  output logic [NUM_SUB_AFUS-1:0]        sub_afu_reset,
  output logic [NUM_SUB_AFUS-1:0]        sub_afu_enable
);

  logic clk;
  logic rst_n;
  assign clk   = pClk;
  assign rst_n = pck_cp2af_softReset_n;

  logic        t1_rd, t1_wr;
  logic [14:0] t1_idx;
  logic [8:0]  t1_tid;
  logic [63:0] t1_data;

  logic        t2_rd, t2_wr;
  t_reg_sel    t2_sel;
  logic [5:0]  t2_sub;
  logic [8:0]  t2_tid;
  logic [63:0] t2_data;

  logic [NUM_SUB_AFUS-1:0]       level_q, level_d;
  logic [NUM_SUB_AFUS-1:0]       enable_q, enable_d;
  logic [63:0]                   scratch_q, scratch_d;
  logic [NUM_SUB_AFUS-1:0][63:0] offset_q, offset_d;
  logic [NUM_SUB_AFUS-1:0]       pulse_load, pulse_active;
  logic [NUM_SUB_AFUS-1:0]       sub_rst_q;
  logic [63:0]                   rd_data;

  logic        t3_valid;
  logic [8:0]  t3_tid;
  logic [63:0] t3_data;

  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  // Address bit 0 selects a 32-bit half and is deliberately dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_rd <= 1'b0; t1_wr <= 1'b0; t1_idx <= '0; t1_tid <= '0; t1_data <= '0;
    end else begin
      t1_rd   <= pck_cp2af_sRx.c0.mmioRdValid;
      t1_wr   <= pck_cp2af_sRx.c0.mmioWrValid;
      t1_idx  <= pck_cp2af_sRx.c0.hdr.address[15:1];
      t1_tid  <= pck_cp2af_sRx.c0.hdr.tid;
      t1_data <= pck_cp2af_sRx.c0.data[63:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t2_rd <= 1'b0; t2_wr <= 1'b0; t2_sel <= REG_NONE; t2_sub <= '0;
      t2_tid <= '0; t2_data <= '0;
    end else begin
      t2_rd   <= t1_rd;
      t2_wr   <= t1_wr;
      t2_sel  <= vai_decode(t1_idx, NUM_SUB_AFUS);
      t2_sub  <= 6'(t1_idx - IDX_OFFSET_BASE);
      t2_tid  <= t1_tid;
      t2_data <= t1_data;
    end
  end

  // Read mux samples the current registers, so a same-cycle write reads back the old value.
  always_comb begin
    level_d    = level_q;
    enable_d   = enable_q;
    scratch_d  = scratch_q;
    offset_d   = offset_q;
    pulse_load = '0;
    rd_data    = '0;
    if (t2_wr) begin
      case (t2_sel)
        REG_PULSE:   pulse_load = t2_data[NUM_SUB_AFUS-1:0];
        REG_LEVEL:   level_d    = t2_data[NUM_SUB_AFUS-1:0];
        REG_ENABLE:  enable_d   = t2_data[NUM_SUB_AFUS-1:0];
        REG_SCRATCH: scratch_d  = t2_data;
        REG_OFFSET:
          for (int i = 0; i < NUM_SUB_AFUS; i++)
            if (t2_sub == 6'(i)) offset_d[i] = t2_data;
        default: ;
      endcase
    end
    case (t2_sel)
      REG_DFH:     rd_data = VAI_MGR_DFH;
      REG_ID_LO:   rd_data = MGR_ID[63:0];
      REG_ID_HI:   rd_data = MGR_ID[127:64];
      REG_PULSE:   rd_data = 64'(pulse_active);
      REG_LEVEL:   rd_data = 64'(level_q);
      REG_ENABLE:  rd_data = 64'(enable_q);
      REG_SCRATCH: rd_data = scratch_q;
      REG_OFFSET:
        for (int i = 0; i < NUM_SUB_AFUS; i++)
          if (t2_sub == 6'(i)) rd_data = offset_q[i];
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_pulse
    vai_reset_pulse #(.RESET_CYCLES(RESET_CYCLES)) u_pulse (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (pulse_load[i]),
      .active (pulse_active[i])
    );
  end

  // Level uses its next value so clearing it releases reset without an extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      enable_q  <= '0;
      scratch_q <= '0;
      offset_q  <= '0;
      sub_rst_q <= '1;
      t3_valid  <= 1'b0;
      t3_tid    <= '0;
      t3_data   <= '0;
    end else begin
      level_q   <= level_d;
      enable_q  <= enable_d;
      scratch_q <= scratch_d;
      offset_q  <= offset_d;
      sub_rst_q <= level_d | pulse_active;
      t3_valid  <= t2_rd;
      t3_tid    <= t2_tid;
      t3_data   <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0; rsp_tid <= '0; rsp_data <= '0;
    end else begin
      rsp_valid <= t3_valid;
      rsp_tid   <= t3_tid;
      rsp_data  <= t3_data;
    end
  end

  always_comb begin
    pck_af2cp_sTx                = '0;
    pck_af2cp_sTx.c2.mmioRdValid = rsp_valid;
    pck_af2cp_sTx.c2.hdr.tid     = rsp_tid;
    pck_af2cp_sTx.c2.data        = rsp_data;
  end

  assign offset_array   = offset_q;
  assign sub_afu_reset  = sub_rst_q;
  assign sub_afu_enable = enable_q;

  logic unused_rx;
  assign unused_rx = &{1'b0, pck_cp2af_sRx.c0TxAlmFull, pck_cp2af_sRx.c1TxAlmFull,
                       pck_cp2af_sRx.c0.hdr.address[0], pck_cp2af_sRx.c0.hdr.length,
                       pck_cp2af_sRx.c0.hdr.rsvd, pck_cp2af_sRx.c0.rspValid,
                       pck_cp2af_sRx.c0.data[511:64]};

endmodule

// File: tb/tb_vai_mgr_csr.sv
// Scoreboard bench for vai_mgr_csr: reads push expected responses from a register
// model, a negedge monitor pops and compares tid, data and arrival cycle.
module tb_vai_mgr_csr;
  import vai_mgr_pkg::*;

  logic                 pClk;
  logic                 rst_n;
  t_if_ccip_Rx          rx;
  t_if_ccip_Tx          tx;
  logic [7:0][63:0]     offset_array;
  logic [7:0]           sub_afu_reset;
  logic [7:0]           sub_afu_enable;

  vai_mgr_csr #(
    .NUM_SUB_AFUS (8),
    .RESET_CYCLES (16),
    .MGR_ID       (128'hd1d383aaca4c4c60a0a013a421139e69)
  ) dut (
    .pClk                  (pClk),
    .pck_cp2af_softReset_n (rst_n),
    .pck_cp2af_sRx         (rx),
    .pck_af2cp_sTx         (tx),
    .offset_array          (offset_array),
    .sub_afu_reset         (sub_afu_reset),
    .sub_afu_enable        (sub_afu_enable)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  int cyc = 0;
  always @(posedge pClk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [8:0]  next_tid = 9'd0;

  logic [7:0]  model_level, model_enable, model_pulse;
  logic [63:0] model_scratch;
  logic [63:0] model_offset [8];

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic model_reset();
    model_level = '0; model_enable = '0; model_scratch = '0; model_pulse = '0;
    for (int i = 0; i < 8; i++) model_offset[i] = '0;
  endtask

  function automatic logic [63:0] model_read(input logic [14:0] idx);
    case (idx)
      15'd0: return 64'h1000_0100_0000_0000;
      15'd1: return 64'ha0a013a421139e69;
      15'd2: return 64'hd1d383aaca4c4c60;
      15'd3: return {56'b0, model_pulse};
      15'd4: return {56'b0, model_level};
      15'd5: return {56'b0, model_enable};
      15'd6: return model_scratch;
      default:
        if (idx >= 15'd8 && idx < 15'd16) return model_offset[int'(idx) - 8];
        else return 64'b0;
    endcase
  endfunction

  task automatic model_write(input logic [14:0] idx, input logic [63:0] data);
    case (idx)
      15'd4: model_level   = data[7:0];
      15'd5: model_enable  = data[7:0];
      15'd6: model_scratch = data;
      default:
        if (idx >= 15'd8 && idx < 15'd16) model_offset[int'(idx) - 8] = data;
    endcase
  endtask

  // Drives one MMIO beat for the current cycle; read expectation uses the pre-write model.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr,
                               input logic [63:0] data, input bit expect_rsp);
    rx = '0;
    rx.c0.hdr.address  = addr;
    rx.c0.hdr.tid      = next_tid;
    rx.c0.data         = {448'b0, data};
    rx.c0.mmioRdValid  = rd;
    rx.c0.mmioWrValid  = wr;
    if (rd) begin
      if (expect_rsp) sb.push_back('{tid: next_tid, data: model_read(addr[15:1]), cyc: cyc + 4});
      next_tid = next_tid + 9'd1;
    end
    if (wr) model_write(addr[15:1], data);
  endtask

  task automatic next_cycle();
    @(negedge pClk);
    rx.c0.mmioRdValid = 1'b0;
    rx.c0.mmioWrValid = 1'b0;
  endtask

  always @(negedge pClk) begin
    if (tx.c2.mmioRdValid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", {55'b0, tx.c2.hdr.tid}, 64'h1ff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_tid", {55'b0, tx.c2.hdr.tid}, {55'b0, e.tid});
        checkOutput("rsp_data", tx.c2.data, e.data);
        checkOutput("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int n, p0, r, m;
    bit ok;
    logic [7:0] e;
    rx = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge pClk);
    checkOutput("reset_sub_rst", {56'b0, sub_afu_reset}, 64'hff);
    checkOutput("reset_enable", {56'b0, sub_afu_enable}, 64'h0);
    checkOutput("reset_offsets", {63'b0, |offset_array}, 64'h0);
    checkOutput("reset_tx", {63'b0, |tx}, 64'h0);

    rst_n = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge pClk);
      if (sub_afu_reset !== 8'hff) ok = 1'b0;
    end
    checkOutput("release_hold16", {63'b0, ok}, 64'h1);
    @(negedge pClk);
    checkOutput("release_drop", {56'b0, sub_afu_reset}, 64'h0);

    // Fixed registers, back to back, including an odd address.
    applyStimulus(1, 0, 16'h0000, 64'h0, 1); next_cycle();
    applyStimulus(1, 0, 16'h0002, 64'h0, 1); next_cycle();
    applyStimulus(1, 0, 16'h0004, 64'h0, 1); next_cycle();
    applyStimulus(1, 0, 16'h0003, 64'h0, 1); next_cycle();
    repeat (6) next_cycle();

    n = cyc;
    applyStimulus(0, 1, 16'h001E, 64'hDEAD_BEEF_0000_1000, 1); next_cycle();
    applyStimulus(1, 0, 16'h001E, 64'h0, 1); next_cycle();
    checkOutput("offset7_n2", 64'(cyc - n), 64'd2);
    checkOutput("offset7_before", offset_array[7], 64'h0);
    next_cycle();
    checkOutput("offset7_after", offset_array[7], 64'hDEAD_BEEF_0000_1000);
    repeat (6) next_cycle();

    // Pulse on bits 0 and 2, retrigger bit 0 on the 8th pulse cycle.
    p0 = cyc;
    r  = p0 + 11;
    applyStimulus(0, 1, 16'h0006, 64'h5, 1); next_cycle();
    while (cyc <= r + 21) begin
      e = '0;
      if (cyc >= p0 + 4 && cyc <= r + 19)  e[0] = 1'b1;
      if (cyc >= p0 + 4 && cyc <= p0 + 19) e[2] = 1'b1;
      checkOutput("pulse_rst", {56'b0, sub_afu_reset}, {56'b0, e});
      if (cyc == r) applyStimulus(0, 1, 16'h0006, 64'h1, 1);
      if (cyc == p0 + 6) begin
        model_pulse = 8'h05;
        applyStimulus(1, 0, 16'h0006, 64'h0, 1);
        model_pulse = 8'h00;
      end
      next_cycle();
    end

    applyStimulus(0, 1, 16'h0008, 64'h80, 1); next_cycle();
    applyStimulus(0, 1, 16'h0006, 64'h80, 1); next_cycle();
    repeat (25) next_cycle();
    checkOutput("level_hold", {56'b0, sub_afu_reset}, 64'h80);
    applyStimulus(1, 0, 16'h0008, 64'h0, 1); next_cycle();
    applyStimulus(1, 0, 16'h0006, 64'h0, 1); next_cycle();
    repeat (4) next_cycle();
    m = cyc;
    applyStimulus(0, 1, 16'h0008, 64'h0, 1); next_cycle();
    next_cycle();
    checkOutput("level_clear_n2", {56'b0, sub_afu_reset}, 64'h80);
    next_cycle();
    checkOutput("level_clear_n3", {56'b0, sub_afu_reset}, 64'h0);
    checkOutput("level_clear_cyc", 64'(cyc - m), 64'd3);

    applyStimulus(0, 1, 16'h000A, 64'hFFFF_0000_0000_00A5, 1); next_cycle();
    next_cycle();
    checkOutput("enable_n2", {56'b0, sub_afu_enable}, 64'h0);
    next_cycle();
    checkOutput("enable_n3", {56'b0, sub_afu_enable}, 64'hA5);
    applyStimulus(1, 0, 16'h000A, 64'h0, 1); next_cycle();

    applyStimulus(0, 1, 16'h000C, 64'h0123_4567_89AB_CDEF, 1); next_cycle();
    applyStimulus(1, 0, 16'h0040, 64'h0, 1); next_cycle();
    applyStimulus(1, 0, 16'h000D, 64'h0, 1); next_cycle();
    applyStimulus(1, 0, 16'h000E, 64'h0, 1); next_cycle();
    applyStimulus(0, 1, 16'h0040, 64'h5555_AAAA_5555_AAAA, 1); next_cycle();
    applyStimulus(1, 0, 16'h0040, 64'h0, 1); next_cycle();
    applyStimulus(1, 1, 16'h000C, 64'hCAFE_F00D_1234_5678, 1); next_cycle();
    applyStimulus(1, 0, 16'h000C, 64'h0, 1); next_cycle();
    repeat (8) next_cycle();

    // Reset lands while a read is in decode; it must vanish without a response.
    applyStimulus(1, 0, 16'h000C, 64'h0, 0); next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("midrst_sub_rst", {56'b0, sub_afu_reset}, 64'hff);
    checkOutput("midrst_enable", {56'b0, sub_afu_enable}, 64'h0);
    checkOutput("midrst_offsets", {63'b0, |offset_array}, 64'h0);
    checkOutput("midrst_tx", {63'b0, |tx}, 64'h0);
    repeat (3) next_cycle();
    rst_n = 1'b1;
    repeat (20) next_cycle();
    applyStimulus(1, 0, 16'h000C, 64'h0, 1); next_cycle();
    applyStimulus(1, 0, 16'h001E, 64'h0, 1); next_cycle();

    for (int k = 0; k < 20 && sb.size() != 0; k++) next_cycle();
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    repeat (2) next_cycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
